// File: rtl/axi4_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_slave_regs
// Purpose  : AXI4-Lite responder backed by NUM_REGS 32-bit read/write
//            registers decoded at BASE_ADDR (word aligned). Register
//            contents are exported to fabric logic together with a one-cycle
//            per-register write strobe.
// Ports    : clk, rst (sync, active-high)
//            AW : s_awaddr, s_awcache, s_awprot, s_awvalid, s_awready
//            W  : s_wdata, s_wstrb, s_wvalid, s_wready
//            B  : s_bresp, s_bvalid, s_bready
//            AR : s_araddr, s_arcache, s_arprot, s_arvalid, s_arready
//            R  : s_rdata, s_rresp, s_rvalid, s_rready
//            reg_out  : register k at [32k+31:32k]
//            wr_pulse : bit k pulses for one cycle when register k is written
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_slave_regs #(
    parameter int          NUM_REGS    = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              s_awaddr,
    input  logic [3:0]               s_awcache,
    input  logic [2:0]               s_awprot,
    input  logic                     s_awvalid,
    output logic                     s_awready,
    input  logic [31:0]              s_wdata,
    input  logic [3:0]               s_wstrb,
    input  logic                     s_wvalid,
    output logic                     s_wready,
    output logic [1:0]               s_bresp,
    output logic                     s_bvalid,
    input  logic                     s_bready,
    input  logic [31:0]              s_araddr,
    input  logic [3:0]               s_arcache,
    input  logic [2:0]               s_arprot,
    input  logic                     s_arvalid,
    output logic                     s_arready,
    output logic [31:0]              s_rdata,
    output logic [1:0]               s_rresp,
    output logic                     s_rvalid,
    input  logic                     s_rready,
    output logic [NUM_REGS*32-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    localparam int          c_IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [31:0] c_SPAN        = 32'(NUM_REGS * 4);
    localparam logic [1:0]  c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  c_RESP_SLVERR = 2'b10;

    logic [31:0]         r_regs [NUM_REGS];
    logic                r_aw_held;
    logic [31:0]         r_aw_addr;
    logic                r_w_held;
    logic [31:0]         r_w_data;
    logic [3:0]          r_w_strb;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic                r_rvalid;
    logic [1:0]          r_rresp;
    logic [31:0]         r_rdata;
    logic [NUM_REGS-1:0] r_wr_pulse;

    logic                w_aw_fire;
    logic                w_w_fire;
    logic                w_ar_fire;
    logic                w_commit;
    logic [32:0]         w_wr_diff;
    logic                w_wr_hit;
    logic [c_IDX_W-1:0]  w_wr_idx;
    logic [32:0]         w_rd_diff;
    logic                w_rd_hit;
    logic [c_IDX_W-1:0]  w_rd_idx;
    logic [NUM_REGS-1:0] w_wr_sel;
    logic [31:0]         w_rd_data;
    logic                w_unused;

    // Protection/cache attributes carry no meaning for a plain register file.
    assign w_unused = ^{s_awcache, s_awprot, s_arcache, s_arprot};

    // Readies come from registered state only, never from valid/ready inputs.
    assign s_awready = !r_aw_held && !r_bvalid;
    assign s_wready  = !r_w_held  && !r_bvalid;
    assign s_arready = !r_rvalid;

    assign w_aw_fire = s_awvalid && s_awready;
    assign w_w_fire  = s_wvalid  && s_wready;
    assign w_ar_fire = s_arvalid && s_arready;
    assign w_commit  = r_aw_held && r_w_held;

    // Decode via a 33-bit subtraction: bit 32 is the borrow, i.e. addr < BASE_ADDR.
    assign w_wr_diff = {1'b0, r_aw_addr} - {1'b0, BASE_ADDR};
    assign w_wr_hit  = !w_wr_diff[32] && (w_wr_diff[31:0] < c_SPAN);
    assign w_wr_idx  = w_wr_diff[c_IDX_W+1:2];
    assign w_rd_diff = {1'b0, s_araddr} - {1'b0, BASE_ADDR};
    assign w_rd_hit  = !w_rd_diff[32] && (w_rd_diff[31:0] < c_SPAN);
    assign w_rd_idx  = w_rd_diff[c_IDX_W+1:2];

    // One-hot write select and read mux; loops keep out-of-range indices
    // (non power-of-two NUM_REGS) from ever addressing a register.
    always_comb begin
        w_wr_sel  = '0;
        w_rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_commit && w_wr_hit && (w_wr_idx == c_IDX_W'(k))) begin
                w_wr_sel[k] = 1'b1;
            end
            if (w_rd_hit && (w_rd_idx == c_IDX_W'(k))) begin
                w_rd_data = r_regs[k];
            end
        end
    end

    // Write address / data holding registers and the response channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_aw_addr <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
        end else begin
            if (w_aw_fire) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= s_awaddr;
            end
            if (w_w_fire) begin
                r_w_held <= 1'b1;
                r_w_data <= s_wdata;
                r_w_strb <= s_wstrb;
            end
            if (w_commit) begin
                // Holds cannot refill here: both readies are low while held.
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_hit ? c_RESP_OKAY : c_RESP_SLVERR;
            end else if (r_bvalid && s_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Register file with byte-lane merge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= RESET_VALUE;
            end
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= w_wr_sel;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_wr_sel[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (r_w_strb[b]) begin
                            r_regs[k][8*b +: 8] <= r_w_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read channel. The read samples r_regs before any same-edge commit,
    // so a colliding read returns the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rresp  <= c_RESP_OKAY;
            r_rdata  <= '0;
        end else begin
            if (w_ar_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_hit ? c_RESP_OKAY : c_RESP_SLVERR;
            end else if (r_rvalid && s_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign s_bvalid = r_bvalid;
    assign s_bresp  = r_bresp;
    assign s_rvalid = r_rvalid;
    assign s_rresp  = r_rresp;
    assign s_rdata  = r_rdata;
    assign wr_pulse = r_wr_pulse;

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
            assign reg_out[32*k +: 32] = r_regs[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_slave_regs
// Purpose  : Directed self-checking bench for axi4_lite_slave_regs
//            (8 registers at base 0, reset value 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_slave_regs;

    localparam int NUM_REGS = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [31:0]            s_awaddr;
    logic [3:0]             s_awcache;
    logic [2:0]             s_awprot;
    logic                   s_awvalid;
    logic                   s_awready;
    logic [31:0]            s_wdata;
    logic [3:0]             s_wstrb;
    logic                   s_wvalid;
    logic                   s_wready;
    logic [1:0]             s_bresp;
    logic                   s_bvalid;
    logic                   s_bready;
    logic [31:0]            s_araddr;
    logic [3:0]             s_arcache;
    logic [2:0]             s_arprot;
    logic                   s_arvalid;
    logic                   s_arready;
    logic [31:0]            s_rdata;
    logic [1:0]             s_rresp;
    logic                   s_rvalid;
    logic                   s_rready;
    logic [NUM_REGS*32-1:0] reg_out;
    logic [NUM_REGS-1:0]    wr_pulse;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi4_lite_slave_regs #(
        .NUM_REGS    (NUM_REGS),
        .BASE_ADDR   (32'h0000_0000),
        .RESET_VALUE (32'h0000_0000)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .s_awaddr  (s_awaddr),
        .s_awcache (s_awcache),
        .s_awprot  (s_awprot),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arcache (s_arcache),
        .s_arprot  (s_arprot),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .reg_out   (reg_out),
        .wr_pulse  (wr_pulse)
    );

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // AW and W presented together; both readies are high when idle.
    task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        s_awaddr  = a;
        s_wdata   = d;
        s_wstrb   = s;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
    endtask

    // Single read with rready high; returns what R showed after the AR edge.
    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] r, output logic v);
        s_araddr  = a;
        s_arvalid = 1'b1;
        s_rready  = 1'b1;
        tick();
        s_arvalid = 1'b0;
        v = s_rvalid;
        d = s_rdata;
        r = s_rresp;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++; if (reg_out !== '0) begin bad++; $display("FAIL reset_regs: got %h want 0", reg_out); end
        total++; if ({s_bvalid, s_rvalid} !== 2'b00) begin bad++; $display("FAIL reset_valids: got %b want 00", {s_bvalid, s_rvalid}); end
        total++; if (wr_pulse !== '0) begin bad++; $display("FAIL reset_pulse: got %h want 00", wr_pulse); end
        rst = 1'b0;
        tick();
        total++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin bad++; $display("FAIL reset_readies: got %b want 111", {s_awready, s_wready, s_arready}); end
    endtask

    task automatic test_basic_write();
        logic [31:0] d; logic [1:0] r; logic v;
        s_bready = 1'b1;
        send_aw_w(32'h4, 32'hDEADBEEF, 4'hF);
        total++; if (s_bvalid !== 1'b0) begin bad++; $display("FAIL basic_early_b: got %b want 0", s_bvalid); end
        tick();
        total++; if ({s_bvalid, s_bresp} !== 3'b100) begin bad++; $display("FAIL basic_b: got %b want 100", {s_bvalid, s_bresp}); end
        total++; if (reg_out[63:32] !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_reg1: got %h want deadbeef", reg_out[63:32]); end
        total++; if (wr_pulse !== 8'h02) begin bad++; $display("FAIL basic_pulse: got %h want 02", wr_pulse); end
        tick();
        total++; if ({s_bvalid, wr_pulse} !== 9'h000) begin bad++; $display("FAIL basic_b_clear: got %h want 000", {s_bvalid, wr_pulse}); end
        do_read(32'h4, d, r, v);
        total++; if ({v, r, d} !== {1'b1, 2'b00, 32'hDEADBEEF}) begin bad++; $display("FAIL basic_read: got %b %b %h want 1 00 deadbeef", v, r, d); end
    endtask

    task automatic test_w_before_aw();
        int extra = 0;
        s_wdata  = 32'h11223344;
        s_wstrb  = 4'b0101;
        s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        tick();
        tick();
        total++; if ({s_wready, s_awready, s_bvalid} !== 3'b010) begin bad++; $display("FAIL wfirst_hold: got %b want 010", {s_wready, s_awready, s_bvalid}); end
        s_awaddr  = 32'h4;
        s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        total++; if (s_bvalid !== 1'b0) begin bad++; $display("FAIL wfirst_early_b: got %b want 0", s_bvalid); end
        tick();
        total++; if ({s_bvalid, s_bresp} !== 3'b100) begin bad++; $display("FAIL wfirst_b: got %b want 100", {s_bvalid, s_bresp}); end
        total++; if (reg_out[63:32] !== 32'hDE22BE44) begin bad++; $display("FAIL wfirst_merge: got %h want de22be44", reg_out[63:32]); end
        tick();
        repeat (4) begin
            if (s_bvalid) extra++;
            tick();
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL wfirst_single_b: got %0d extra cycles want 0", extra); end
    endtask

    task automatic test_miss();
        logic [31:0] d; logic [1:0] r; logic v;
        logic [NUM_REGS*32-1:0] exp_regs;
        exp_regs = '0;
        exp_regs[63:32] = 32'hDE22BE44;
        send_aw_w(32'h20, 32'hFFFFFFFF, 4'hF);
        tick();
        total++; if ({s_bvalid, s_bresp} !== 3'b110) begin bad++; $display("FAIL miss_b: got %b want 110", {s_bvalid, s_bresp}); end
        total++; if (wr_pulse !== 8'h00) begin bad++; $display("FAIL miss_pulse: got %h want 00", wr_pulse); end
        total++; if (reg_out !== exp_regs) begin bad++; $display("FAIL miss_regs: got %h want %h", reg_out, exp_regs); end
        tick();
        do_read(32'h20, d, r, v);
        total++; if ({v, r, d} !== {1'b1, 2'b10, 32'h0}) begin bad++; $display("FAIL miss_read: got %b %b %h want 1 10 0", v, r, d); end
    endtask

    task automatic test_zero_strb();
        send_aw_w(32'h0, 32'hFFFFFFFF, 4'h0);
        tick();
        total++; if (wr_pulse !== 8'h01) begin bad++; $display("FAIL zstrb_pulse: got %h want 01", wr_pulse); end
        total++; if (reg_out[31:0] !== 32'h0) begin bad++; $display("FAIL zstrb_reg0: got %h want 0", reg_out[31:0]); end
        tick();
    endtask

    task automatic test_backpressure();
        s_bready = 1'b0;
        send_aw_w(32'hC, 32'h000000A5, 4'hF);
        tick();
        for (int i = 0; i < 5; i++) begin
            total++; if ({s_bvalid, s_bresp, s_awready, s_wready} !== 5'b10000) begin bad++; $display("FAIL bstall_%0d: got %b want 10000", i, {s_bvalid, s_bresp, s_awready, s_wready}); end
            tick();
        end
        s_bready = 1'b1;
        tick();
        total++; if ({s_bvalid, s_awready, s_wready} !== 3'b011) begin bad++; $display("FAIL bstall_release: got %b want 011", {s_bvalid, s_awready, s_wready}); end
        s_rready  = 1'b0;
        s_araddr  = 32'hC;
        s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if ({s_rvalid, s_arready, s_rresp, s_rdata} !== {2'b10, 2'b00, 32'h000000A5}) begin bad++; $display("FAIL rstall_%0d: got %b %b %b %h want 1 0 00 000000a5", i, s_rvalid, s_arready, s_rresp, s_rdata); end
            tick();
        end
        s_rready = 1'b1;
        tick();
        total++; if ({s_rvalid, s_arready} !== 2'b01) begin bad++; $display("FAIL rstall_release: got %b want 01", {s_rvalid, s_arready}); end
    endtask

    task automatic test_collision();
        logic [31:0] d; logic [1:0] r; logic v;
        send_aw_w(32'h8, 32'h5A5A5A5A, 4'hF);
        s_araddr  = 32'h8;
        s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        total++; if ({s_rvalid, s_rdata} !== {1'b1, 32'h0}) begin bad++; $display("FAIL coll_old: got %b %h want 1 0", s_rvalid, s_rdata); end
        total++; if ({s_bvalid, reg_out[95:64]} !== {1'b1, 32'h5A5A5A5A}) begin bad++; $display("FAIL coll_write: got %b %h want 1 5a5a5a5a", s_bvalid, reg_out[95:64]); end
        tick();
        do_read(32'h8, d, r, v);
        total++; if ({v, r, d} !== {1'b1, 2'b00, 32'h5A5A5A5A}) begin bad++; $display("FAIL coll_reread: got %b %b %h want 1 00 5a5a5a5a", v, r, d); end
    endtask

    task automatic test_reset_inflight();
        s_awaddr  = 32'h10;
        s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        total++; if ({s_awready, s_wready} !== 2'b01) begin bad++; $display("FAIL rif_held: got %b want 01", {s_awready, s_wready}); end
        s_wdata  = 32'hCAFEF00D;
        s_wstrb  = 4'hF;
        s_wvalid = 1'b1;
        rst      = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
        s_wvalid = 1'b0;
        total++; if ({s_bvalid, reg_out} !== {1'b0, {NUM_REGS*32{1'b0}}}) begin bad++; $display("FAIL rif_regs: got %b %h want 0 0", s_bvalid, reg_out); end
        tick();
        tick();
        total++; if ({s_bvalid, wr_pulse, s_awready, s_wready} !== 11'b0_00000000_11) begin bad++; $display("FAIL rif_after: got %b want 00000000011", {s_bvalid, wr_pulse, s_awready, s_wready}); end
    endtask

    initial begin
        s_awaddr = '0; s_awcache = '0; s_awprot = '0; s_awvalid = 1'b0;
        s_wdata  = '0; s_wstrb   = '0; s_wvalid = 1'b0;
        s_bready = 1'b1;
        s_araddr = '0; s_arcache = '0; s_arprot = '0; s_arvalid = 1'b0;
        s_rready = 1'b1;
        rst      = 1'b1;
        test_reset();
        test_basic_write();
        test_w_before_aw();
        test_miss();
        test_zero_strb();
        test_backpressure();
        test_collision();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
